pipeline_seq_ctrl: RTL and testbench
====================================

PIPELINE_SEQ_CTRL -- requirements
Module: pipeline_seq_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive identical synchronized samples required to accept a button level; legal range 1-255.
REQ-002 Parameter RUN_DIV, default 8: clock cycles between automatic advances in run mode; legal range 2-255.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 resetN  input  1  synchronous, active-low reset.
REQ-005 btnStep  input  1  raw push button; request a single pipeline advance.
REQ-006 btnRun  input  1  raw push button; toggle free-run mode.
REQ-007 btnWRselect  input  1  raw push button; toggle register-write source select.
REQ-008 btnMuxEx  input  1  raw push button; toggle EX operand mux select.
REQ-009 jmpReq  input  1  decode-stage branch request, level, sampled on advance cycles.
REQ-010 jmpAddr  input  4  branch target address.
REQ-011 zeroAlu  input  1  ALU zero flag from EX stage.
REQ-012 stageEn  output  5  enables: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB.
REQ-013 flush  output  1  clears IF/ID and ID/EX contents.
REQ-014 pcLoad  output  1  load PC from pcLoadAddr.
REQ-015 pcLoadAddr  output  4  PC load value.
REQ-016 wrSelect  output  1  register-write source select level.
REQ-017 muxExSel  output  1  EX mux select level.
REQ-018 runMode  output  1  high while free-running.
REQ-019 stepCount  output  8  count of completed advances.

Function
REQ-020 Each button input SHALL pass through a two-flop synchronizer and then a debouncer that updates its debounced level only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-021 A rising edge of a debounced level SHALL produce exactly one 1-cycle internal pulse; the pulse SHALL occur between DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+4 cycles after the raw input becomes stable high.
REQ-022 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no pulse.
REQ-023 FSM states: IDLE, ADV, RUN, FLUSH.
REQ-024 IDLE: a run pulse SHALL go to RUN with runMode=1; otherwise a step pulse SHALL go to ADV; when both pulses occur in the same cycle, run wins and the step pulse is dropped.
REQ-025 ADV: stageEn=5'b11111 for exactly one cycle, stepCount increments by 1 (wrapping 255->0), next state is IDLE.
REQ-026 RUN: a divider counter SHALL assert stageEn=5'b11111 for one cycle every RUN_DIV cycles, with the first advance RUN_DIV cycles after entry; each advance increments stepCount; step pulses are ignored.
REQ-027 RUN: a run pulse SHALL return the FSM to IDLE, clear runMode, and reset the divider; no advance occurs in that cycle.
REQ-028 On any advance cycle where jmpReq=1 and zeroAlu=1 (branch taken), the block SHALL assert pcLoad=1 and pcLoadAddr=jmpAddr in that same cycle, and the next state SHALL be FLUSH.
REQ-029 FLUSH: flush=1 and stageEn=0 for exactly one cycle; the FSM then returns to RUN if runMode=1, else to IDLE; the divider restarts on return to RUN.
REQ-030 Pulses arriving in ADV or FLUSH SHALL be discarded, except run pulses, which clear runMode so that the FSM returns to IDLE.
REQ-031 wrSelect and muxExSel SHALL toggle on their respective debounced pulses in any state, taking effect on the cycle after the pulse.
REQ-032 stageEn, flush and pcLoad SHALL be registered and SHALL never be asserted together except stageEn with pcLoad on a branch-taken advance.
REQ-033 pcLoadAddr SHALL hold its last loaded value when pcLoad=0.

Reset
REQ-034 When resetN=0 at a clock edge: state=IDLE, stageEn=0, flush=0, pcLoad=0, pcLoadAddr=0, wrSelect=0, muxExSel=0, runMode=0, stepCount=0, divider=0, synchronizers, debounce counters and debounced levels=0.
REQ-035 Reset asserted mid-ADV, mid-RUN or mid-FLUSH SHALL abort the operation with no further enable or flush pulses.
REQ-036 A button held high through reset release SHALL yield one pulse after debounce.

Verification
REQ-037 Reset, then btnStep high for 10 cycles (DEBOUNCE_CYCLES=4) -> exactly one stageEn=11111 cycle, stepCount=1, runMode=0.
REQ-038 btnStep 2-cycle glitch -> no stageEn assertion, stepCount unchanged.
REQ-039 btnRun pulse, wait 40 cycles (RUN_DIV=8), then btnRun pulse -> 4 or 5 advances spaced exactly 8 cycles apart, runMode returns to 0.
REQ-040 In step mode, jmpReq=1, zeroAlu=1, jmpAddr=4'hA at an advance -> pcLoad=1 with pcLoadAddr=4'hA in that same cycle, then flush=1 with stageEn=0 for one cycle, then IDLE.
REQ-041 btnWRselect pressed twice, then btnMuxEx pressed once -> wrSelect 0->1->0, muxExSel=1.
REQ-042 stepCount=255 followed by one step, and resetN=0 asserted during RUN -> stepCount wraps to 0; after reset all outputs hold their reset values with no further enables.

Source files
------------

// File: rtl/pipeline_seq_ctrl.sv
// Single-step / free-run sequencer for a 5-stage teaching pipeline.
// Raw buttons are synchronized and debounced, then drive an advance/branch/flush FSM.
module pipeline_seq_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RUN_DIV         = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       btnStep,
    input  logic       btnRun,
    input  logic       btnWRselect,
    input  logic       btnMuxEx,
    input  logic       jmpReq,
    input  logic [3:0] jmpAddr,
    input  logic       zeroAlu,
    output logic [4:0] stageEn,
    output logic       flush,
    output logic       pcLoad,
    output logic [3:0] pcLoadAddr,
    output logic       wrSelect,
    output logic       muxExSel,
    output logic       runMode,
    output logic [7:0] stepCount
);

    localparam int         NB       = 4;
    localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] DIV_LAST = 8'(RUN_DIV - 1);

    typedef enum logic [1:0] {IDLE, ADV, RUN, FLUSH} state_t;

    logic [NB-1:0]      btn_raw;
    logic [NB-1:0]      sync0_q, sync0_d, sync1_q, sync1_d;
    logic [NB-1:0]      deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [NB-1:0][7:0] db_cnt_q, db_cnt_d;
    logic [NB-1:0]      pulse;

    assign btn_raw = {btnMuxEx, btnWRselect, btnRun, btnStep};

    // Counter tracks how long the synchronized sample has disagreed with the accepted level.
    always_comb begin
        sync0_d    = btn_raw;
        sync1_d    = sync0_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        db_cnt_d   = '0;
        for (int i = 0; i < NB; i++) begin
            if (sync1_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync1_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign pulse = deb_q & ~deb_prev_q;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            sync0_q    <= '0;
            sync1_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            db_cnt_q   <= '0;
        end else begin
            sync0_q    <= sync0_d;
            sync1_q    <= sync1_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    state_t     state_q, state_d;
    logic [4:0] stage_en_q, stage_en_d;
    logic       flush_q, flush_d;
    logic       pc_load_q, pc_load_d;
    logic [3:0] pc_load_addr_q, pc_load_addr_d;
    logic       wr_select_q, wr_select_d;
    logic       mux_ex_sel_q, mux_ex_sel_d;
    logic       run_mode_q, run_mode_d;
    logic [7:0] step_count_q, step_count_d;
    logic [7:0] div_q, div_d;
    logic       advance;
    logic       step_p, run_p;

    assign step_p = pulse[0];
    assign run_p  = pulse[1];

    // Outputs are computed one cycle ahead so the ADV state coincides with stageEn high;
    // the branch decision is taken together with the advance so pcLoad lands in the same cycle.
    always_comb begin
        state_d        = state_q;
        stage_en_d     = '0;
        flush_d        = 1'b0;
        pc_load_d      = 1'b0;
        pc_load_addr_d = pc_load_addr_q;
        wr_select_d    = wr_select_q ^ pulse[2];
        mux_ex_sel_d   = mux_ex_sel_q ^ pulse[3];
        run_mode_d     = run_mode_q;
        step_count_d   = step_count_q;
        div_d          = div_q;
        advance        = 1'b0;

        case (state_q)
            IDLE: begin
                if (run_p) begin
                    state_d    = RUN;
                    run_mode_d = 1'b1;
                    div_d      = '0;
                end else if (step_p) begin
                    advance = 1'b1;
                end
            end
            RUN: begin
                if (run_p) begin
                    state_d    = IDLE;
                    run_mode_d = 1'b0;
                    div_d      = '0;
                end else if (div_q == DIV_LAST) begin
                    advance = 1'b1;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ADV: begin
                if (run_p) begin
                    run_mode_d = 1'b0;
                    div_d      = '0;
                end else if (run_mode_q) begin
                    div_d = div_q + 8'd1;
                end
                if (pc_load_q) begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                end else begin
                    state_d = run_mode_d ? RUN : IDLE;
                end
            end
            FLUSH: begin
                if (run_p) begin
                    run_mode_d = 1'b0;
                end
                div_d   = '0;
                state_d = run_mode_d ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            state_d      = ADV;
            stage_en_d   = 5'b11111;
            step_count_d = step_count_q + 8'd1;
            if (jmpReq && zeroAlu) begin
                pc_load_d      = 1'b1;
                pc_load_addr_d = jmpAddr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q        <= IDLE;
            stage_en_q     <= '0;
            flush_q        <= 1'b0;
            pc_load_q      <= 1'b0;
            pc_load_addr_q <= '0;
            wr_select_q    <= 1'b0;
            mux_ex_sel_q   <= 1'b0;
            run_mode_q     <= 1'b0;
            step_count_q   <= '0;
            div_q          <= '0;
        end else begin
            state_q        <= state_d;
            stage_en_q     <= stage_en_d;
            flush_q        <= flush_d;
            pc_load_q      <= pc_load_d;
            pc_load_addr_q <= pc_load_addr_d;
            wr_select_q    <= wr_select_d;
            mux_ex_sel_q   <= mux_ex_sel_d;
            run_mode_q     <= run_mode_d;
            step_count_q   <= step_count_d;
            div_q          <= div_d;
        end
    end

    assign stageEn    = stage_en_q;
    assign flush      = flush_q;
    assign pcLoad     = pc_load_q;
    assign pcLoadAddr = pc_load_addr_q;
    assign wrSelect   = wr_select_q;
    assign muxExSel   = mux_ex_sel_q;
    assign runMode    = run_mode_q;
    assign stepCount  = step_count_q;

endmodule

// File: tb/tb_pipeline_seq_ctrl.sv
// Scoreboard bench for pipeline_seq_ctrl: expected advances are queued when a
// button is pressed and retired whenever the DUT shows stageEn=11111.
module tb_pipeline_seq_ctrl;

    logic       clk = 1'b0;
    logic       resetN, btnStep, btnRun, btnWRselect, btnMuxEx, jmpReq, zeroAlu;
    logic [3:0] jmpAddr;
    logic [4:0] stageEn;
    logic       flush, pcLoad, wrSelect, muxExSel, runMode;
    logic [3:0] pcLoadAddr;
    logic [7:0] stepCount;

    pipeline_seq_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(8)) dut (
        .clk(clk), .resetN(resetN), .btnStep(btnStep), .btnRun(btnRun),
        .btnWRselect(btnWRselect), .btnMuxEx(btnMuxEx), .jmpReq(jmpReq),
        .jmpAddr(jmpAddr), .zeroAlu(zeroAlu), .stageEn(stageEn), .flush(flush),
        .pcLoad(pcLoad), .pcLoadAddr(pcLoadAddr), .wrSelect(wrSelect),
        .muxExSel(muxExSel), .runMode(runMode), .stepCount(stepCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cnt;
        logic       pcl;
        logic [3:0] addr;
    } adv_t;

    adv_t       exp_q[$];
    int         adv_cyc[$];
    int         flush_cyc[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] model_cnt = 8'd0;
    logic [3:0] model_addr = 4'd0;

    // One cycle: sample at negedge and retire any advance against the scoreboard.
    task automatic tick(input int n);
        adv_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (stageEn == 5'b11111) begin
                adv_cyc.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL adv_unexpected cyc=%0d stepCount=%0d required no advance", cyc, stepCount);
                end else begin
                    e = exp_q.pop_front();
                    if ({stepCount, pcLoad, pcLoadAddr} !== {e.cnt, e.pcl, e.addr}) begin
                        bad++;
                        $display("FAIL adv_data cyc=%0d got cnt=%0d pcl=%b addr=%h required cnt=%0d pcl=%b addr=%h",
                                 cyc, stepCount, pcLoad, pcLoadAddr, e.cnt, e.pcl, e.addr);
                    end
                end
            end else if (stageEn !== 5'b00000) begin
                total++;
                bad++;
                $display("FAIL stage_partial cyc=%0d stageEn=%b required 00000 or 11111", cyc, stageEn);
            end
            if (flush === 1'b1) begin
                flush_cyc.push_back(cyc);
                total++;
                if (stageEn !== 5'b0 || pcLoad !== 1'b0) begin
                    bad++;
                    $display("FAIL flush_excl cyc=%0d stageEn=%b pcLoad=%b required 0 0", cyc, stageEn, pcLoad);
                end
            end
        end
    endtask

    task automatic drive_btn(input int b, input logic v);
        case (b)
            0: btnStep = v;
            1: btnRun = v;
            2: btnWRselect = v;
            default: btnMuxEx = v;
        endcase
    endtask

    task automatic press(input int b, input int hi, input int lo);
        drive_btn(b, 1'b1);
        tick(hi);
        drive_btn(b, 1'b0);
        tick(lo);
    endtask

    task automatic push_adv(input logic pcl, input logic [3:0] addr);
        adv_t e;
        model_cnt = model_cnt + 8'd1;
        if (pcl) model_addr = addr;
        e.cnt = model_cnt;
        e.pcl = pcl;
        e.addr = model_addr;
        exp_q.push_back(e);
    endtask

    task automatic check_queue_empty(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got %0d outstanding advances required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        tick(3);
        total++;
        if ({stageEn, flush, pcLoad, pcLoadAddr, wrSelect, muxExSel, runMode, stepCount} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs got en=%b fl=%b pl=%b addr=%h wr=%b mx=%b run=%b cnt=%0d required all 0",
                     stageEn, flush, pcLoad, pcLoadAddr, wrSelect, muxExSel, runMode, stepCount);
        end
        resetN = 1'b1;
        tick(2);
    endtask

    task automatic test_step();
        int a0 = adv_cyc.size();
        push_adv(1'b0, 4'h0);
        press(0, 10, 14);
        check_queue_empty("step");
        total++;
        if (adv_cyc.size() - a0 != 1 || stepCount !== 8'd1 || runMode !== 1'b0) begin
            bad++;
            $display("FAIL step_single got advances=%0d cnt=%0d run=%b required 1 1 0",
                     adv_cyc.size() - a0, stepCount, runMode);
        end
    endtask

    task automatic test_glitch();
        int a0 = adv_cyc.size();
        press(0, 2, 16);
        total++;
        if (adv_cyc.size() != a0 || stepCount !== model_cnt) begin
            bad++;
            $display("FAIL glitch got advances=%0d cnt=%0d required 0 %0d", adv_cyc.size() - a0, stepCount, model_cnt);
        end
    endtask

    task automatic test_run();
        int a0 = adv_cyc.size();
        int n;
        logic [7:0] base = model_cnt;
        for (int i = 0; i < 5; i++) push_adv(1'b0, 4'h0);
        press(1, 8, 32);
        total++;
        if (runMode !== 1'b1) begin
            bad++;
            $display("FAIL run_mode_on got %b required 1", runMode);
        end
        press(1, 8, 24);
        n = adv_cyc.size() - a0;
        exp_q.delete();
        model_cnt = base + 8'(n);
        total++;
        if (n < 4 || n > 5) begin
            bad++;
            $display("FAIL run_count got %0d advances required 4 or 5", n);
        end
        for (int i = a0 + 1; i < adv_cyc.size(); i++) begin
            total++;
            if (adv_cyc[i] - adv_cyc[i-1] != 8) begin
                bad++;
                $display("FAIL run_spacing got %0d cycles required 8", adv_cyc[i] - adv_cyc[i-1]);
            end
        end
        total++;
        if (runMode !== 1'b0 || stepCount !== model_cnt) begin
            bad++;
            $display("FAIL run_exit got run=%b cnt=%0d required 0 %0d", runMode, stepCount, model_cnt);
        end
    endtask

    task automatic test_branch();
        int a0 = adv_cyc.size();
        int f0 = flush_cyc.size();
        jmpReq = 1'b1;
        zeroAlu = 1'b1;
        jmpAddr = 4'hA;
        push_adv(1'b1, 4'hA);
        press(0, 10, 14);
        check_queue_empty("branch");
        total++;
        if (adv_cyc.size() != a0 + 1 || flush_cyc.size() != f0 + 1) begin
            bad++;
            $display("FAIL branch_events got advances=%0d flushes=%0d required 1 1",
                     adv_cyc.size() - a0, flush_cyc.size() - f0);
        end else if (flush_cyc[f0] != adv_cyc[a0] + 1) begin
            bad++;
            $display("FAIL branch_flush_cycle got %0d required %0d", flush_cyc[f0], adv_cyc[a0] + 1);
        end
        total++;
        if (pcLoadAddr !== 4'hA || pcLoad !== 1'b0 || flush !== 1'b0 || stageEn !== 5'b0) begin
            bad++;
            $display("FAIL branch_idle got addr=%h pl=%b fl=%b en=%b required a 0 0 00000",
                     pcLoadAddr, pcLoad, flush, stageEn);
        end
        zeroAlu = 1'b0;
        f0 = flush_cyc.size();
        push_adv(1'b0, 4'h0);
        press(0, 10, 14);
        check_queue_empty("not_taken");
        total++;
        if (flush_cyc.size() != f0 || pcLoadAddr !== 4'hA) begin
            bad++;
            $display("FAIL not_taken got flushes=%0d addr=%h required 0 a", flush_cyc.size() - f0, pcLoadAddr);
        end
        jmpReq = 1'b0;
    endtask

    task automatic test_toggles();
        press(2, 8, 12);
        total++;
        if (wrSelect !== 1'b1) begin
            bad++;
            $display("FAIL wr_first got %b required 1", wrSelect);
        end
        press(2, 8, 12);
        total++;
        if (wrSelect !== 1'b0) begin
            bad++;
            $display("FAIL wr_second got %b required 0", wrSelect);
        end
        press(3, 8, 12);
        total++;
        if (muxExSel !== 1'b1 || wrSelect !== 1'b0) begin
            bad++;
            $display("FAIL mux_toggle got mux=%b wr=%b required 1 0", muxExSel, wrSelect);
        end
    endtask

    task automatic test_wrap();
        int a0 = adv_cyc.size();
        int k = 250 - int'(model_cnt);
        int budget = 0;
        logic [7:0] base = model_cnt;
        for (int i = 0; i < k + 5; i++) push_adv(1'b0, 4'h0);
        drive_btn(1, 1'b1);
        tick(8);
        drive_btn(1, 1'b0);
        while (adv_cyc.size() - a0 < k && budget < 4000) begin
            tick(1);
            budget++;
        end
        total++;
        if (adv_cyc.size() - a0 < k) begin
            bad++;
            $display("FAIL wrap_run_timeout got %0d advances required %0d", adv_cyc.size() - a0, k);
        end
        press(1, 8, 20);
        model_cnt = base + 8'(adv_cyc.size() - a0);
        exp_q.delete();
        total++;
        if (runMode !== 1'b0 || stepCount !== model_cnt) begin
            bad++;
            $display("FAIL wrap_run_stop got run=%b cnt=%0d required 0 %0d", runMode, stepCount, model_cnt);
        end
        for (int i = 0; i < 12 && model_cnt != 8'd0; i++) begin
            push_adv(1'b0, 4'h0);
            press(0, 10, 14);
        end
        check_queue_empty("wrap");
        total++;
        if (stepCount !== 8'd0) begin
            bad++;
            $display("FAIL wrap_value got %0d required 0", stepCount);
        end
    endtask

    task automatic test_reset_in_run();
        int a0;
        for (int i = 0; i < 10; i++) push_adv(1'b0, 4'h0);
        press(1, 8, 30);
        exp_q.delete();
        resetN = 1'b0;
        a0 = adv_cyc.size();
        tick(3);
        total++;
        if ({stageEn, flush, pcLoad, pcLoadAddr, wrSelect, muxExSel, runMode, stepCount} !== 22'd0) begin
            bad++;
            $display("FAIL reset_run_outputs got en=%b fl=%b pl=%b addr=%h run=%b cnt=%0d required all 0",
                     stageEn, flush, pcLoad, pcLoadAddr, runMode, stepCount);
        end
        resetN = 1'b1;
        model_cnt = 8'd0;
        model_addr = 4'd0;
        tick(40);
        total++;
        if (adv_cyc.size() != a0 || runMode !== 1'b0 || stepCount !== 8'd0 || flush !== 1'b0) begin
            bad++;
            $display("FAIL reset_run_quiet got advances=%0d run=%b cnt=%0d fl=%b required 0 0 0 0",
                     adv_cyc.size() - a0, runMode, stepCount, flush);
        end
    endtask

    task automatic test_held_through_reset();
        int a0;
        btnStep = 1'b1;
        resetN = 1'b0;
        tick(4);
        a0 = adv_cyc.size();
        resetN = 1'b1;
        model_cnt = 8'd0;
        push_adv(1'b0, 4'h0);
        tick(12);
        btnStep = 1'b0;
        tick(14);
        check_queue_empty("held");
        total++;
        if (adv_cyc.size() - a0 != 1 || stepCount !== 8'd1) begin
            bad++;
            $display("FAIL held_reset got advances=%0d cnt=%0d required 1 1", adv_cyc.size() - a0, stepCount);
        end
    endtask

    initial begin
        resetN = 1'b0;
        btnStep = 1'b0;
        btnRun = 1'b0;
        btnWRselect = 1'b0;
        btnMuxEx = 1'b0;
        jmpReq = 1'b0;
        zeroAlu = 1'b0;
        jmpAddr = 4'h0;
        test_reset();
        test_step();
        test_glitch();
        test_run();
        test_branch();
        test_toggles();
        test_wrap();
        test_reset_in_run();
        test_held_through_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
